ssd_pattern_decoder: RTL
========================

// Module: ssd_pattern_decoder
// PURPOSE
//  Inverse of the team's hex-to-7-segment encoder. Watches a multiplexed 7-seg bus
//  (segment lines + per-digit anode selects) and recovers the 4-bit hex value shown on each digit.
//  Sits beside the display driver in the hot/cold game as a self-check and readback path.
//  Also usable as a bench monitor. A pattern is only accepted after it has been stable long enough.
// PARAMETERS
//  NUM_DIGITS     4  number of multiplexed digits / anode lines (1..8)
//  STABLE_CYCLES  4  consecutive identical samples required before capture (>=1)
//  ACTIVE_LOW     0  1: segment and anode inputs are active-low; they are inverted at the input register
// PORTS
//  clk          in   1             system clock, rising edge
//  reset        in   1             asynchronous, active-high; clears all state
//  segment      in   7             {a,b,c,d,e,f,g}; bit6 = a, bit0 = g
//  an           in   NUM_DIGITS    digit select; bit i = digit i
//  digits       out  4*NUM_DIGITS  recovered values; digit i in [4i+3:4i]
//  digit_valid  out  NUM_DIGITS    1 = digits[i] holds a decoded legal pattern
//  cap_stb      out  1             1-cycle pulse on every capture event
//  pattern_err  out  1             1-cycle pulse: illegal pattern or non-one-hot anode captured
// BEHAVIOUR
//  - Reset: digits = 0, digit_valid = 0, cap_stb = 0, pattern_err = 0, stability counter = 0, FSM = IDLE.
//    Reset asserted mid-count or mid-capture aborts immediately.
//    After release, a full STABLE_CYCLES window is needed again.
//  - Input stage: {an, segment} are registered each edge into S (inverted first if ACTIVE_LOW=1).
//    The raw inputs are never decoded directly.
//  - Stability counter: if S == previous S, cnt increments, saturating at STABLE_CYCLES; otherwise cnt = 0.
//  - FSM:
//    - IDLE: entered when S.an == 0; no capture. Leaves to TRACK when S.an != 0.
//    - TRACK: counting. When cnt reaches STABLE_CYCLES-1 (S unchanged for STABLE_CYCLES samples),
//      capture on the next edge and go to LOCKED.
//    - LOCKED: no further capture. Any change of S -> TRACK with cnt = 0. S.an == 0 -> IDLE.
//  - Latency: inputs held constant starting at edge t -> outputs and cap_stb update at edge t+STABLE_CYCLES+1.
//  - Decode table (segment -> value):
//      7E->0  30->1  6D->2  79->3  33->4  5B->5  5F->6  70->7
//      7F->8  73->9  77->A  1F->B  4E->C  3D->D  4F->E  47->F   (hex of segment[6:0])
//  - Capture with one-hot an selecting digit i:
//    - legal pattern: digits[i] = value, digit_valid[i] = 1, cap_stb = 1.
//    - segment == 00 (blank): digit_valid[i] = 0, digits[i] unchanged, cap_stb = 1, no error.
//    - any other pattern (including 05): digit_valid[i] = 0, digits[i] unchanged, cap_stb = 1, pattern_err = 1.
//  - Capture with an nonzero but not one-hot: no digit is updated, cap_stb = 1, pattern_err = 1.
//  - Other digits are never disturbed by a capture.
//  - Re-capture of a digit overwrites its previous value; no sticky state.
//  - cap_stb and pattern_err are high for exactly one cycle per capture event.
//  - A pattern flickering faster than STABLE_CYCLES never captures. The counter restarts on every change.
// TESTING
//  1. Reset, then an=0001, segment=7E held 10 cycles ->
//     digits[3:0]=0, digit_valid=0001, one cap_stb exactly 5 edges after first sample (defaults).
//  2. Scan all 16 table patterns on digit 2 (an=0100), each held 8 cycles ->
//     digits[11:8] follows 0..F, valid stays 1, no pattern_err, 16 cap_stb pulses.
//  3. an=0010, segment=05 held 8 cycles -> pattern_err 1 pulse, digit_valid[1]=0, digits[7:4] retains prior value.
//  4. an=0011, segment=30 held 8 cycles -> cap_stb + pattern_err, digits/digit_valid unchanged.
//  5. segment alternates 30/6D every 2 cycles on an=0001 for 20 cycles -> no cap_stb.
//     Then hold 6D -> digits[3:0]=2.
//  6. Assert reset during cycle 3 of a stable window, release, keep inputs ->
//     all outputs 0 during reset; capture occurs STABLE_CYCLES+1 edges after release, not earlier.

Source files
------------

// File: rtl/ssd_pattern_decoder.sv
// ssd_pattern_decoder: recovers hex digits from a multiplexed 7-segment bus once a pattern has been stable
module ssd_pattern_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [6:0]                segment,
  input  logic [NUM_DIGITS-1:0]     an,
  output logic [4*NUM_DIGITS-1:0]   digits,
  output logic [NUM_DIGITS-1:0]     digit_valid,
  output logic                      cap_stb,
  output logic                      pattern_err
);
  localparam int W  = NUM_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;
  state_t state, state_n;
  logic [W-1:0] s_in, s, s_prev;
  logic [NUM_DIGITS-1:0] s_an, wr;
  logic [6:0] s_seg;
  logic [CW-1:0] cnt;
  logic same, one_hot, fire, dec_ok, cap, err;
  logic [3:0] dec_val;
  assign s_in    = (ACTIVE_LOW != 0) ? ~{an, segment} : {an, segment};
  assign s_an    = s[W-1:7];
  assign s_seg   = s[6:0];
  assign same    = s == s_prev;
  assign one_hot = (s_an != '0) && ((s_an & (s_an - NUM_DIGITS'(1))) == '0);
  assign fire    = (state == TRACK) && same && (cnt == CW'(STABLE_CYCLES - 1));
  // register the bus twice so stability is judged only on sampled values
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s      <= '0;
      s_prev <= '0;
    end else begin
      s      <= s_in;
      s_prev <= s;
    end
  // count consecutive identical samples, saturating, restarting on any change
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (!same) cnt <= '0;
    else if (cnt != CW'(STABLE_CYCLES)) cnt <= cnt + CW'(1);
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // next state: blank anodes idle, tracking locks on capture, any change while locked rearms
  always_comb
    state_n = (s_an == '0)      ? IDLE :
              (state == TRACK)  ? (fire ? LOCKED : TRACK) :
              (state == LOCKED) ? (same ? LOCKED : TRACK) : TRACK;
  // segment pattern to hex value lookup
  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'h0;
    case (s_seg)
      7'h7E: dec_val = 4'h0;
      7'h30: dec_val = 4'h1;
      7'h6D: dec_val = 4'h2;
      7'h79: dec_val = 4'h3;
      7'h33: dec_val = 4'h4;
      7'h5B: dec_val = 4'h5;
      7'h5F: dec_val = 4'h6;
      7'h70: dec_val = 4'h7;
      7'h7F: dec_val = 4'h8;
      7'h73: dec_val = 4'h9;
      7'h77: dec_val = 4'hA;
      7'h1F: dec_val = 4'hB;
      7'h4E: dec_val = 4'hC;
      7'h3D: dec_val = 4'hD;
      7'h4F: dec_val = 4'hE;
      7'h47: dec_val = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end
  // capture effects: a blank digit clears valid silently, anything else undecodable is an error
  always_comb begin
    cap = fire;
    err = fire && (!one_hot || (!dec_ok && s_seg != 7'h00));
    wr  = (fire && one_hot) ? s_an : '0;
  end
  // output registers; only the selected digit is touched by a capture
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      digits      <= '0;
      digit_valid <= '0;
      cap_stb     <= 1'b0;
      pattern_err <= 1'b0;
    end else begin
      cap_stb     <= cap;
      pattern_err <= err;
      for (int k = 0; k < NUM_DIGITS; k++)
        if (wr[k]) begin
          digit_valid[k] <= dec_ok;
          if (dec_ok) digits[4*k +: 4] <= dec_val;
        end
    end
endmodule
